// File: rtl/mux_seq_pkg.sv
// mux_seq_pkg: shared constants for the mux_seq block.
//   MUX_SEQ_WIDTH_DEF / MUX_SEQ_NCH_DEF : default data width and channel count
//   MODE_MANUAL / MODE_SCAN             : encoding of the mode input
// Optional feature macro used by the block: MUX_SEQ_PARITY_EN.
package mux_seq_pkg;
    localparam int MUX_SEQ_WIDTH_DEF = 8;
    localparam int MUX_SEQ_NCH_DEF   = 4;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;
endpackage

// File: rtl/mux_seq_if.sv
// mux_seq_if: bundles the data/control/status signals of mux_seq.
//   d        : NCH*WIDTH flattened channel data (channel k at [k*WIDTH +: WIDTH])
//   en       : capture / scan-advance enable
//   mode     : 0 = manual, 1 = scan
//   sel_load : load sel_in into the select register
//   sel_in   : channel number to load
//   y        : registered selected data
//   y_valid  : y captured on the previous edge
//   cur_sel  : current select register value
//   wrap     : one-cycle pulse when the scan wraps NCH-1 -> 0
//   y_par    : even parity of y (only with MUX_SEQ_PARITY_EN)
// Modports: master drives the inputs of the block, slave is the block itself.
// Handshake: there is no back-pressure; en qualifies each cycle and y_valid
// marks the cycle after an enabled capture.
import mux_seq_pkg::*;

interface mux_seq_if #(
    parameter int WIDTH = MUX_SEQ_WIDTH_DEF,
    parameter int NCH   = MUX_SEQ_NCH_DEF
);
    localparam int SELW = $clog2(NCH);

    logic [NCH*WIDTH-1:0] d;
    logic                 en;
    logic                 mode;
    logic                 sel_load;
    logic [SELW-1:0]      sel_in;
    logic [WIDTH-1:0]     y;
    logic                 y_valid;
    logic [SELW-1:0]      cur_sel;
    logic                 wrap;
`ifdef MUX_SEQ_PARITY_EN
    logic                 y_par;
`endif

    modport master (
`ifdef MUX_SEQ_PARITY_EN
        input  y_par,
`endif
        output d, en, mode, sel_load, sel_in,
        input  y, y_valid, cur_sel, wrap
    );

    modport slave (
`ifdef MUX_SEQ_PARITY_EN
        output y_par,
`endif
        input  d, en, mode, sel_load, sel_in,
        output y, y_valid, cur_sel, wrap
    );
endinterface

// File: rtl/mux_seq_sel_cnt.sv
// mux_seq_sel_cnt: select register with explicit load, auto-scan and wrap flag.
//   clk, reset   : clock, synchronous active-high reset
//   en_i         : scan advance enable
//   mode_i       : MODE_MANUAL / MODE_SCAN
//   sel_load_i   : load request
//   sel_in_i     : value to load (ignored when >= NCH)
//   sel_o        : select register
//   wrap_o       : registered pulse, set when a scan step goes NCH-1 -> 0
import mux_seq_pkg::*;

module mux_seq_sel_cnt #(
    parameter int NCH  = MUX_SEQ_NCH_DEF,
    parameter int SELW = $clog2(NCH)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en_i,
    input  logic            mode_i,
    input  logic            sel_load_i,
    input  logic [SELW-1:0] sel_in_i,
    output logic [SELW-1:0] sel_o,
    output logic            wrap_o
);
    // One extra bit so NCH itself is representable for the range check.
    localparam logic [SELW:0]   NCH_W    = (SELW+1)'(NCH);
    localparam logic [SELW-1:0] LAST_SEL = SELW'(NCH - 1);

    logic [SELW-1:0] sel_q, sel_d;
    logic            wrap_q, wrap_d;

    always_comb begin
        sel_d  = sel_q;
        wrap_d = 1'b0;
        if (sel_load_i) begin
            // An out-of-range load swallows the cycle: no load, no scan step.
            if ({1'b0, sel_in_i} < NCH_W) begin
                sel_d = sel_in_i;
            end
        end else if (mode_i == MODE_SCAN && en_i) begin
            if (sel_q == LAST_SEL) begin
                sel_d  = '0;
                wrap_d = 1'b1;
            end else begin
                sel_d = sel_q + SELW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sel_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            sel_q  <= sel_d;
            wrap_q <= wrap_d;
        end
    end

    assign sel_o  = sel_q;
    assign wrap_o = wrap_q;
endmodule

// File: rtl/mux_seq.sv
// mux_seq: N-channel registered multiplexer with registered select and scan mode.
//   clk   : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : mux_seq_if.slave (d, en, mode, sel_load, sel_in in;
//           y, y_valid, cur_sel, wrap out; y_par out with MUX_SEQ_PARITY_EN)
// Capture uses the select value from before the edge, so a load or scan step
// on the same edge only affects the following capture.
import mux_seq_pkg::*;

module mux_seq #(
    parameter int WIDTH = MUX_SEQ_WIDTH_DEF,
    parameter int NCH   = MUX_SEQ_NCH_DEF
) (
    input  logic     clk,
    input  logic     reset,
    mux_seq_if.slave bus
);
    localparam int SELW = $clog2(NCH);

    logic [SELW-1:0]  sel;
    logic [WIDTH-1:0] chan;
    logic [WIDTH-1:0] y_q, y_d;
    logic             y_valid_q, y_valid_d;

    mux_seq_sel_cnt #(
        .NCH  (NCH),
        .SELW (SELW)
    ) u_sel_cnt (
        .clk        (clk),
        .reset      (reset),
        .en_i       (bus.en),
        .mode_i     (bus.mode),
        .sel_load_i (bus.sel_load),
        .sel_in_i   (bus.sel_in),
        .sel_o      (sel),
        .wrap_o     (bus.wrap)
    );

    // Decoded selection; unreachable select codes (non power-of-2 NCH) give 0.
    always_comb begin
        chan = '0;
        for (int k = 0; k < NCH; k++) begin
            if (sel == SELW'(k)) begin
                chan = bus.d[k*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        y_d       = y_q;
        y_valid_d = 1'b0;
        if (bus.en) begin
            y_d       = chan;
            y_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            y_q       <= '0;
            y_valid_q <= 1'b0;
        end else begin
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
        end
    end

`ifdef MUX_SEQ_PARITY_EN
    logic y_par_q, y_par_d;

    always_comb begin
        y_par_d = y_par_q;
        if (bus.en) begin
            y_par_d = ^chan;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            y_par_q <= 1'b0;
        end else begin
            y_par_q <= y_par_d;
        end
    end

    assign bus.y_par = y_par_q;
`endif

    assign bus.y       = y_q;
    assign bus.y_valid = y_valid_q;
    assign bus.cur_sel = sel;
endmodule

// File: tb/tb_mux_seq.sv
// tb_mux_seq: drives a 4-channel and a 3-channel mux_seq from shared controls
// and checks them against a behavioural model every cycle, plus literal
// checkpoints for the directed scenarios. Optional MUX_SEQ_PARITY_EN adds y_par.
`timescale 1ns/1ps
import mux_seq_pkg::*;

module tb_mux_seq;
  typedef struct {
    int sel;
    int y;
    bit valid;
    bit wrap;
    bit par;
  } model_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        en, mode, ld;
  logic [1:0]  sel_in;
  logic [31:0] d4;
  logic [23:0] d3;

  int n_checks = 0;
  int n_fail   = 0;
  bit started  = 0;

  model_t m4, m3;
  logic [7:0] exp_q[$];

  mux_seq_if #(.WIDTH(8), .NCH(4)) if4 ();
  mux_seq_if #(.WIDTH(8), .NCH(3)) if3 ();

  assign if4.d = d4;      assign if3.d = d3;
  assign if4.en = en;     assign if3.en = en;
  assign if4.mode = mode; assign if3.mode = mode;
  assign if4.sel_load = ld;   assign if3.sel_load = ld;
  assign if4.sel_in = sel_in; assign if3.sel_in = sel_in;

  mux_seq #(.WIDTH(8), .NCH(4)) u_dut4 (.clk(clk), .reset(reset), .bus(if4.slave));
  mux_seq #(.WIDTH(8), .NCH(3)) u_dut3 (.clk(clk), .reset(reset), .bus(if3.slave));

  // clock / reset
  always #5 clk = ~clk;

  // Behavioural next-state: what the outputs must show after one edge.
  function automatic model_t model_step(model_t m, int nch, logic rst, logic en_v,
                                        logic mode_v, logic ld_v, int sin, logic [31:0] dv);
    model_t n;
    logic [7:0] ch;
    if (rst) begin
      n.sel = 0; n.y = 0; n.valid = 0; n.wrap = 0; n.par = 0;
      return n;
    end
    n = m;
    n.wrap = 0;
    ch = 8'((dv >> (m.sel * 8)) & 32'hFF);
    if (en_v) begin
      n.y = int'(ch);
      n.valid = 1;
      n.par = ^ch;
    end else begin
      n.valid = 0;
    end
    if (ld_v) begin
      if (sin < nch) n.sel = sin;
    end else if (mode_v && en_v) begin
      n.sel = (m.sel + 1) % nch;
      n.wrap = (n.sel == 0);
    end
    return n;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // model update + per-cycle compare
  always @(posedge clk) begin
    if (reset) started = 1;
    if (started) begin
      if (en && !reset) exp_q.push_back(8'((d4 >> (m4.sel * 8)) & 32'hFF));
      if (reset) exp_q.delete();
      m4 = model_step(m4, 4, reset, en, mode, ld, int'(sel_in), d4);
      m3 = model_step(m3, 3, reset, en, mode, ld, int'(sel_in), {8'h00, d3});
    end
    #2;
    if (started) begin
      check("dut4_y_valid", {31'd0, if4.y_valid}, {31'd0, m4.valid});
      check("dut4_cur_sel", {30'd0, if4.cur_sel}, m4.sel);
      check("dut4_wrap",    {31'd0, if4.wrap},    {31'd0, m4.wrap});
      if (m4.valid && exp_q.size() > 0) check("dut4_y_sb", {24'd0, if4.y}, {24'd0, exp_q.pop_front()});
      else check("dut4_y_hold", {24'd0, if4.y}, m4.y);
      check("dut3_y",       {24'd0, if3.y},       m3.y);
      check("dut3_y_valid", {31'd0, if3.y_valid}, {31'd0, m3.valid});
      check("dut3_cur_sel", {30'd0, if3.cur_sel}, m3.sel);
      check("dut3_wrap",    {31'd0, if3.wrap},    {31'd0, m3.wrap});
`ifdef MUX_SEQ_PARITY_EN
      check("dut4_y_par",   {31'd0, if4.y_par},   {31'd0, m4.par});
      check("dut3_y_par",   {31'd0, if3.y_par},   {31'd0, m3.par});
`endif
    end
  end

  // driver tasks
  task automatic cycle();
    @(posedge clk);
    #4;
  endtask

  task automatic drive(logic r, logic e, logic md, logic l, logic [1:0] si);
    reset = r; en = e; mode = md; ld = l; sel_in = si;
  endtask

  // literal checkpoint: y, y_valid, cur_sel, wrap for one instance
  task automatic pin4(string tag, int y, int v, int s, int w);
    check({tag, "_y4"},    {24'd0, if4.y},       y);
    check({tag, "_v4"},    {31'd0, if4.y_valid}, v);
    check({tag, "_sel4"},  {30'd0, if4.cur_sel}, s);
    check({tag, "_wrap4"}, {31'd0, if4.wrap},    w);
  endtask

  task automatic pin3(string tag, int y, int s, int w);
    check({tag, "_y3"},    {24'd0, if3.y},       y);
    check({tag, "_sel3"},  {30'd0, if3.cur_sel}, s);
    check({tag, "_wrap3"}, {31'd0, if3.wrap},    w);
  endtask

  int ys4[5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
  int ss4[5] = '{1, 2, 3, 0, 1};
  int ys3[5] = '{8'h11, 8'h22, 8'h33, 8'h11, 8'h22};
  int ss3[5] = '{1, 2, 0, 1, 2};

  initial begin
    d4 = 32'h44332211;
    d3 = 24'h332211;
    drive(1, 0, MODE_MANUAL, 0, 0);

    // reset then idle
    cycle(); cycle();
    pin4("reset", 0, 0, 0, 0);
    pin3("reset", 0, 0, 0);
    drive(0, 0, MODE_MANUAL, 0, 0);
    cycle(); cycle();
    pin4("idle", 0, 0, 0, 0);

    // manual load of channel 2, then capture
    drive(0, 0, MODE_MANUAL, 1, 2);
    cycle();
    pin4("load2", 0, 0, 2, 0);
    drive(0, 1, MODE_MANUAL, 0, 0);
    cycle();
    pin4("manual_cap", 8'h33, 1, 2, 0);

    // back to channel 0, then scan 5 enabled cycles
    drive(0, 0, MODE_MANUAL, 1, 0);
    cycle();
    drive(0, 1, MODE_SCAN, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cycle();
      pin4("scan", ys4[i], 1, ss4[i], (i == 3) ? 1 : 0);
      pin3("scan", ys3[i], ss3[i], (i == 2) ? 1 : 0);
    end

    // load during scan: dut4 sel=1 loads 3; dut3 sel=2 ignores sel_in=3
    drive(0, 1, MODE_SCAN, 1, 3);
    cycle();
    pin4("scanload", 8'h22, 1, 3, 0);
    pin3("badload", 8'h33, 2, 0);
    drive(0, 1, MODE_SCAN, 0, 0);
    cycle();
    pin4("after_load", 8'h44, 1, 0, 1);
    pin3("after_bad", 8'h33, 0, 1);

    // reset mid-scan
    cycle(); cycle();
    check("pre_reset_sel4", {30'd0, if4.cur_sel}, 2);
    drive(1, 1, MODE_SCAN, 0, 0);
    cycle();
    pin4("midreset", 0, 0, 0, 0);
    drive(0, 1, MODE_SCAN, 0, 0);
    cycle();
    pin4("post_reset", 8'h11, 1, 1, 0);

    // randomized phase
    for (int i = 0; i < 400; i++) begin
      d4 = $urandom;
      d3 = 24'($urandom);
      drive(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0),
            2'($urandom_range(0, 3)));
      cycle();
    end

`ifdef MUX_SEQ_PARITY_EN
    d4 = 32'h00000307;
    drive(1, 0, MODE_MANUAL, 0, 0);
    cycle();
    drive(0, 1, MODE_MANUAL, 1, 1);
    cycle();
    check("par_07", {31'd0, if4.y_par}, 1);
    check("par_07_y", {24'd0, if4.y}, 8'h07);
    drive(0, 1, MODE_MANUAL, 0, 0);
    cycle();
    check("par_03", {31'd0, if4.y_par}, 0);
    check("par_03_y", {24'd0, if4.y}, 8'h03);
`endif

    drive(0, 0, MODE_MANUAL, 0, 0);
    cycle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
